// File: rtl/alu_seq_unit_if.sv
// Command/response channels of alu_seq_unit.
// The flag signals exist only when ALU_SEQ_FLAGS_EN is defined.
interface alu_seq_unit_if #(parameter int WIDTH = 16);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;
`ifdef ALU_SEQ_FLAGS_EN
    logic             flag_z;
    logic             flag_c;
`endif

    modport master (
        output in_valid, opcode, A, B, out_ready,
`ifdef ALU_SEQ_FLAGS_EN
        input  flag_z, flag_c,
`endif
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, opcode, A, B, out_ready,
`ifdef ALU_SEQ_FLAGS_EN
        output flag_z, flag_c,
`endif
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked 16-bit ALU with a multi-cycle shift-add multiplier.
// Define ALU_SEQ_FLAGS_EN to add the registered zero and carry flags.
//
// state  | meaning
// S_IDLE | waiting for a command, in_ready high
// S_BUSY | MUL in progress, one shift-add step per clock
// S_DONE | response presented, held until out_ready
module alu_seq_unit #(
    parameter int WIDTH      = 16,
    parameter int MUL_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_seq_unit_if.slave bus
);
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   op_a_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_step;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   alu_res;
    logic [SH_W-1:0]    sh;
    logic               out_valid_q;
    logic               in_ready;
    logic               accept;
    logic               mul_last;

    assign sh = bus.B[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (bus.opcode)
            OP_ADD:  alu_res = bus.A + bus.B;
            OP_SUB:  alu_res = bus.A - bus.B;
            OP_AND:  alu_res = bus.A & bus.B;
            OP_OR:   alu_res = bus.A | bus.B;
            OP_XOR:  alu_res = bus.A ^ bus.B;
            OP_SHL:  alu_res = bus.A << sh;
            OP_SLT:  alu_res = WIDTH'(bus.A < bus.B);
            default: alu_res = '0;
        endcase
    end

    // Product register holds {partial sum, remaining multiplier bits}; shift right each step.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, op_a_q} : {(WIDTH+1){1'b0}});
        prod_step = {mul_sum, prod_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        mul_last = 1'b0;
        case (state_q)
            S_IDLE: in_ready = 1'b1;
            S_BUSY: begin
                if (cnt_q == '0) begin
                    mul_last = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                in_ready = bus.out_ready;
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        accept = in_ready & bus.in_valid;
        if (accept) state_d = (bus.opcode == OP_MUL) ? S_BUSY : S_DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic flag_z_q, flag_c_q;
    logic alu_c;

    // Lost SHL bits show up as a mismatch when the result is shifted back.
    always_comb begin
        alu_c = 1'b0;
        case (bus.opcode)
            OP_ADD:  alu_c = (alu_res < bus.A);
            OP_SUB:  alu_c = (bus.A < bus.B);
            OP_SHL:  alu_c = ((alu_res >> sh) != bus.A);
            default: alu_c = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else if (accept && bus.opcode != OP_MUL) begin
            flag_z_q <= (alu_res == '0);
            flag_c_q <= alu_c;
        end else if (!accept && mul_last) begin
            flag_z_q <= (prod_step[WIDTH-1:0] == '0);
            flag_c_q <= |prod_step[2*WIDTH-1:WIDTH];
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            op_a_q      <= '0;
            prod_q      <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= (state_d == S_DONE);
            if (accept) begin
                op_a_q <= bus.A;
                if (bus.opcode == OP_MUL) begin
                    prod_q <= {{WIDTH{1'b0}}, bus.B};
                    cnt_q  <= CNT_W'(MUL_CYCLES - 1);
                end else begin
                    result_q <= alu_res;
                end
            end else if (state_q == S_BUSY) begin
                prod_q <= prod_step;
                if (mul_last) result_q <= prod_step[WIDTH-1:0];
                else          cnt_q    <= cnt_q - 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.Result    = result_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed, table-driven bench for alu_seq_unit, plus back-to-back,
// back-pressure and mid-MUL reset sequences.
module tb_alu_seq_unit;
    localparam int W   = 16;
    localparam int MC  = 16;
    localparam int NV  = 18;

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         z;
        logic         c;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    cmd_t vec [NV];

    always #5 clk = ~clk;

    alu_seq_unit_if #(.WIDTH(W)) bus ();
    alu_seq_unit #(.WIDTH(W), .MUL_CYCLES(MC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input string name, input cmd_t c);
        int cyc;
        int busy;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode   = c.op;
        bus.A        = c.a;
        bus.B        = c.b;
        cyc = 0;
        while (!bus.in_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        cyc  = 0;
        busy = 0;
        while (!bus.out_valid && cyc < 100) begin
            if (!bus.in_ready) busy++;
            @(negedge clk);
            cyc++;
        end
        chk({name, " latency"}, cyc, (c.op == 3'b101) ? MC : 0);
        chk({name, " busy"}, busy, (c.op == 3'b101) ? MC : 0);
        chk({name, " result"}, bus.Result, c.res);
`ifdef ALU_SEQ_FLAGS_EN
        chk({name, " flag_z"}, bus.flag_z, c.z);
        chk({name, " flag_c"}, bus.flag_c, c.c);
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        int   bad;
        int   stale;

        vec[0]  = '{3'b000, 16'd15,   16'd1,    16'd16,   1'b0, 1'b0};
        vec[1]  = '{3'b001, 16'd1,    16'd3,    16'hFFFE, 1'b0, 1'b1};
        vec[2]  = '{3'b111, 16'd3,    16'd4,    16'd1,    1'b0, 1'b0};
        vec[3]  = '{3'b101, 16'd200,  16'd61,   16'h2FA8, 1'b0, 1'b0};
        vec[4]  = '{3'b101, 16'hFFFF, 16'd2,    16'hFFFE, 1'b0, 1'b1};
        vec[5]  = '{3'b100, 16'd10,   16'd10,   16'd0,    1'b1, 1'b0};
        vec[6]  = '{3'b110, 16'd255,  16'd4,    16'h0FF0, 1'b0, 1'b0};
        vec[7]  = '{3'b110, 16'h8001, 16'd1,    16'h0002, 1'b0, 1'b1};
        vec[8]  = '{3'b010, 16'hF0F0, 16'h3CC3, 16'h30C0, 1'b0, 1'b0};
        vec[9]  = '{3'b011, 16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0};
        vec[10] = '{3'b000, 16'hFFFF, 16'd1,    16'h0000, 1'b1, 1'b1};
        vec[11] = '{3'b001, 16'd5,    16'd5,    16'h0000, 1'b1, 1'b0};
        vec[12] = '{3'b111, 16'd4,    16'd3,    16'h0000, 1'b1, 1'b0};
        vec[13] = '{3'b110, 16'd1,    16'd15,   16'h8000, 1'b0, 1'b0};
        vec[14] = '{3'b110, 16'd1,    16'h0013, 16'h0008, 1'b0, 1'b0};
        vec[15] = '{3'b101, 16'h1234, 16'h0100, 16'h3400, 1'b0, 1'b1};
        vec[16] = '{3'b101, 16'd0,    16'd5,    16'h0000, 1'b1, 1'b0};
        vec[17] = '{3'b101, 16'd255,  16'd255,  16'hFE01, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.opcode    = 3'b000;
        bus.A         = '0;
        bus.B         = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset out_valid", bus.out_valid, 0);
        chk("reset Result", bus.Result, 0);
`ifdef ALU_SEQ_FLAGS_EN
        chk("reset flag_z", bus.flag_z, 0);
        chk("reset flag_c", bus.flag_c, 0);
`endif

        for (int i = 0; i < NV; i++) send($sformatf("vec%0d", i), vec[i]);

        // back-to-back SUB then SLT with out_ready high
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.opcode = 3'b001; bus.A = 16'd1; bus.B = 16'd3;
        chk("b2b idle ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.opcode = 3'b111; bus.A = 16'd3; bus.B = 16'd4;
        @(negedge clk);
        chk("b2b sub valid", bus.out_valid, 1);
        chk("b2b sub result", bus.Result, 16'hFFFE);
        chk("b2b done ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("b2b slt valid", bus.out_valid, 1);
        chk("b2b slt result", bus.Result, 16'd1);
        @(negedge clk);
        chk("b2b back to idle", bus.out_valid, 0);

        // back-pressure: XOR held for 5 cycles with a pending ADD
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.opcode = 3'b100; bus.A = 16'd10; bus.B = 16'd10;
        @(posedge clk);
        #1;
        bus.opcode = 3'b000; bus.A = 16'd2; bus.B = 16'd3;
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.Result !== 16'd0 || bus.in_ready !== 1'b0) bad++;
`ifdef ALU_SEQ_FLAGS_EN
            if (bus.flag_z !== 1'b1) bad++;
`endif
        end
        chk("hold stable cycles bad", bad, 0);
        bus.out_ready = 1'b1;
        #1;
        chk("hold release ready", bus.in_ready, 1);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("pending add valid", bus.out_valid, 1);
        chk("pending add result", bus.Result, 16'd5);
        @(negedge clk);

        // reset in the middle of a MUL
        bus.in_valid = 1'b1;
        bus.opcode = 3'b101; bus.A = 16'd34; bus.B = 16'd5;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("mid-mul busy", bus.in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst Result", bus.Result, 0);
        chk("rst in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) stale++;
        end
        chk("no stale response", stale, 0);
        c = '{3'b000, 16'd100, 16'd23, 16'd123, 1'b0, 1'b0};
        send("post-reset add", c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
